intr_seq: RTL and testbench
===========================

# intr_seq

Interrupt and ERET sequencer sitting directly upstream of the CP0 register file. It synchronises six external interrupt lines, latches them as pending, and checks them against the mask and global-enable bits read back from the CP0 status register. At an instruction boundary it runs a fixed multi-cycle write sequence through the CP0 write port: EPC, then Cause, then Status. It then redirects the PC to the handler vector, and on ERET restores Status and redirects to EPC.

## Interface
- `HANDLER_VEC`, default 32'h0000_0800: PC loaded on interrupt entry.
- `SYNC_STAGES`, default 2: flip-flop depth of the irq synchroniser; legal range 2..3.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: reset, synchronous, active-low; `rst`==0 at a rising edge resets the block.
- `irq`  in  6: asynchronous interrupt requests, rising-edge sensitive.
- `sr_rd`  in  16: CP0 status readback. Bit 0 = global IE; bits [15:10] = per-line mask, where bit 10+i enables irq[i].
- `epc_rd`  in  32: CP0 EPC readback.
- `pc_next`  in  32: address of the next instruction to execute; sampled when an interrupt is accepted.
- `boundary`  in  1: an instruction retires this cycle, so an interrupt may be taken.
- `eret`  in  1: an ERET retires this cycle; qualified by `boundary`.
- `cp0_addr`  out  5: CP0 register address.
- `cp0_we`  out  1: CP0 write enable.
- `cp0_din`  out  32: CP0 write data.
- `stall`  out  1: freezes the pipeline while a sequence runs.
- `redirect`  out  1: one-cycle pulse; the PC loads `redirect_pc`.
- `redirect_pc`  out  32: redirect target.
- `irq_pending`  out  6: pending latch, exposed for debug.

## Operation
- Pending latch:
  - A synchronised rising edge on irq[i] sets pending[i].
  - pending[i] clears in the REDIR cycle that services line i.
  - If set and clear coincide on the same line, set wins.
- Eligible lines = pending & sr_rd[15:10]. Priority: highest index wins (irq[5] highest).
- Accept condition: state IDLE, `boundary`=1, sr_rd[0]=1, and at least one eligible line. On accept:
  - `pc_next` is captured.
  - The line index is captured.
- ERET condition: state IDLE, `boundary`=1, `eret`=1. ERET takes precedence over a simultaneous interrupt accept; the interrupt is re-evaluated at the next boundary.
- State machine states: IDLE, W_EPC, W_CAUSE, W_SR, REDIR, E_SR, E_REDIR.
  - IDLE → W_EPC on accept; IDLE → E_SR on ERET.
  - W_EPC → W_CAUSE → W_SR → REDIR → IDLE.
  - E_SR → E_REDIR → IDLE.
  - Every non-IDLE state lasts exactly one cycle.
- Writes per state:
  - W_EPC: addr 5'b01110, data = captured pc.
  - W_CAUSE: addr 5'b01101, data = {16'b0, onehot(line) in [15:10], 10'b0}. ExcCode [6:2] = 0 (interrupt).
  - W_SR: addr 5'b01100, data = {16'b0, sr_rd[15:1], 1'b0} (IE cleared).
  - E_SR: addr 5'b01100, data = {16'b0, sr_rd[15:1], 1'b1}.
- Redirect states:
  - REDIR: `redirect`=1, `redirect_pc`=HANDLER_VEC.
  - E_REDIR: `redirect`=1, `redirect_pc`=epc_rd.
- `cp0_we`=1 only in W_EPC, W_CAUSE, W_SR, E_SR; otherwise `cp0_addr`/`cp0_din` are 0.
- `stall`=1 in every non-IDLE state.
- A new irq edge arriving during a sequence only sets pending; it is never lost.

## Timing
- Accept or ERET in cycle T (combinational check, registered transition).
- Interrupt: W_EPC in T+1, W_CAUSE in T+2, W_SR in T+3, REDIR in T+4, IDLE in T+5. Total 4 stall cycles.
- ERET: E_SR in T+1, E_REDIR in T+2, IDLE in T+3.
- irq edge → pending visible after SYNC_STAGES+1 rising edges.
- All outputs are registered state decodes; no input-to-output combinational path.
- Reset values: state IDLE, pending 0, synchroniser 0; all outputs 0 (`redirect_pc` 0, `cp0_din` 0).
- Reset mid-sequence: the sequence is abandoned the next cycle and no further CP0 writes are issued.

## Configuration
- `INTR_SYNC_EN` defined: SYNC_STAGES-deep synchroniser in front of the edge detector.
- Undefined: irq is treated as synchronous to `clk` and feeds the edge-detect register directly. Pending then becomes visible 1 edge after irq rises, and SYNC_STAGES is ignored.

## Structure
- Shared package holds:
  - the state enum;
  - CP0 address constants (PRID 5'b01000, SR 5'b01100, CAUSE 5'b01101, EPC 5'b01110);
  - Status field positions (IE bit 0, IM [15:10]);
  - Cause field positions (IP [15:10], ExcCode [6:2]).
- One sub-module, `irq_sync`: synchroniser, edge detect and pending latch. It takes per-line clear inputs and outputs `irq_pending`.

## Test plan
- irq[2] pulse, sr_rd=16'hFC01, `boundary` held high, pc_next=32'h0000_0040 → writes EPC=32'h40, Cause=32'h0000_1000, SR=32'h0000_FC00; then redirect to 32'h800; pending[2] cleared.
- irq[1] and irq[4] together, sr_rd=16'hFC01 → line 4 serviced first (Cause=32'h0000_4000); line 1 remains pending.
- sr_rd=16'hFC00 (IE=0) or sr_rd=16'h0001 (mask=0) → no accept while pending; accept follows once sr_rd returns to 16'hFC01.
- ERET with epc_rd=32'h0000_0044, sr_rd=16'hFC00 → SR write 32'h0000_FC01, then redirect to 32'h44; a simultaneous pending interrupt is deferred to the next boundary.
- `rst`=0 asserted in W_CAUSE → cp0_we=0 and stall=0 from the next cycle; no SR write or redirect occurs.
- irq[0] edge during an active sequence → pending[0] set, then serviced in a second sequence starting at the first boundary after IDLE.

Source files
------------

// File: rtl/intr_seq_pkg.sv
// intr_seq_pkg: shared types and constants for the interrupt/ERET sequencer.
//   - FSM state encoding (3-bit constants)
//   - CP0 register addresses and Status/Cause field positions
//   - packed CP0 write-port payload
//   - helpers: priority encoder, one-hot line decode, Cause/Status word builders
package intr_seq_pkg;

    localparam int unsigned NUM_IRQ    = 6;
    localparam int unsigned LINE_W     = 3;
    localparam int unsigned STATE_W    = 3;
    localparam int unsigned CP0_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned SR_W       = 16;

    // FSM state encoding
    typedef logic [STATE_W-1:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_W_EPC   = 3'd1;
    localparam state_t ST_W_CAUSE = 3'd2;
    localparam state_t ST_W_SR    = 3'd3;
    localparam state_t ST_REDIR   = 3'd4;
    localparam state_t ST_E_SR    = 3'd5;
    localparam state_t ST_E_REDIR = 3'd6;

    // CP0 register addresses
    localparam logic [CP0_ADDR_W-1:0] CP0_PRID  = 5'b01000;
    localparam logic [CP0_ADDR_W-1:0] CP0_SR    = 5'b01100;
    localparam logic [CP0_ADDR_W-1:0] CP0_CAUSE = 5'b01101;
    localparam logic [CP0_ADDR_W-1:0] CP0_EPC   = 5'b01110;

    // Status field positions
    localparam int unsigned SR_IE_BIT = 0;
    localparam int unsigned SR_IM_LSB = 10;
    localparam int unsigned SR_IM_MSB = 15;

    // Cause field positions
    localparam int unsigned CAUSE_IP_LSB  = 10;
    localparam int unsigned CAUSE_IP_MSB  = 15;
    localparam int unsigned CAUSE_EXC_LSB = 2;
    localparam int unsigned CAUSE_EXC_MSB = 6;

    // ExcCode for an external interrupt
    localparam logic [CAUSE_EXC_MSB-CAUSE_EXC_LSB:0] EXC_INT = '0;

    // One CP0 write-port transaction
    typedef struct packed {
        logic [CP0_ADDR_W-1:0] addr;
        logic                  we;
        logic [XLEN-1:0]       din;
    } cp0_wr_t;

    // Highest set index wins; returns 0 for an empty vector (caller checks |v)
    function automatic logic [LINE_W-1:0] prio_line(input logic [NUM_IRQ-1:0] v);
        prio_line = '0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (v[i]) prio_line = LINE_W'(i);
        end
    endfunction

    function automatic logic [NUM_IRQ-1:0] line_onehot(input logic [LINE_W-1:0] line);
        line_onehot = NUM_IRQ'(1) << line;
    endfunction

    // Cause word: IP one-hot for the serviced line, ExcCode = interrupt
    function automatic logic [XLEN-1:0] cause_word(input logic [LINE_W-1:0] line);
        logic [XLEN-1:0] w;
        w = XLEN'(line_onehot(line)) << CAUSE_IP_LSB;
        w[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = EXC_INT;
        cause_word = w;
    endfunction

    // Status word with the mask/upper bits preserved and IE forced to ie
    function automatic logic [XLEN-1:0] sr_word(input logic [SR_W-1:0] sr, input logic ie);
        sr_word = {16'b0, sr[SR_W-1:1], ie};
    endfunction

endpackage

// File: rtl/intr_seq_irq.sv
// irq_sync: interrupt input front end.
//   Optional synchroniser (INTR_SYNC_EN), rising-edge detector and pending latch.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   irq[5:0]        raw interrupt requests
//   clr[5:0]        per-line pending clear (set wins on collision)
//   irq_pending     registered pending latch
// Configuration macro: INTR_SYNC_EN (SYNC_STAGES-deep synchroniser); when
// undefined, irq is taken as synchronous and SYNC_STAGES has no effect.
module irq_sync
    import intr_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] clr,
    output logic [NUM_IRQ-1:0] irq_pending
);

`ifdef INTR_SYNC_EN
    localparam int unsigned DEPTH = SYNC_STAGES;
`else
    // Synchroniser bypassed: depth collapses to zero and irq drives the edge detector
    localparam int unsigned DEPTH = 0 * SYNC_STAGES;
`endif

    logic [NUM_IRQ-1:0] src;
    logic [NUM_IRQ-1:0] prev;
    logic [NUM_IRQ-1:0] rise;

    generate
        if (DEPTH == 0) begin : g_direct
            assign src = irq;
        end else begin : g_sync
            logic [DEPTH-1:0][NUM_IRQ-1:0] sync_q;

            // Shift chain; stage DEPTH-1 is the metastability-settled copy
            always_ff @(posedge clk) begin
                if (!rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= irq;
                    for (int k = 1; k < int'(DEPTH); k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign src = sync_q[DEPTH-1];
        end
    endgenerate

    assign rise = src & ~prev;

    // Edge register and pending latch; a new edge overrides a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev        <= '0;
            irq_pending <= '0;
        end else begin
            prev        <= src;
            irq_pending <= (irq_pending & ~clr) | rise;
        end
    end

endmodule

// File: rtl/intr_seq.sv
// intr_seq: interrupt entry / ERET sequencer in front of the CP0 register file.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   irq[5:0]            interrupt requests (rising-edge sensitive)
//   sr_rd, epc_rd       CP0 Status / EPC readback
//   pc_next             next PC, captured as EPC on interrupt accept
//   boundary, eret      instruction-retire and ERET-retire strobes
//   cp0_addr/we/din     CP0 write port
//   stall               pipeline freeze while a sequence runs
//   redirect, redirect_pc  one-cycle PC redirect
//   irq_pending         pending latch (debug)
// Configuration macro: INTR_SYNC_EN (see irq_sync).
module intr_seq
    import intr_seq_pkg::*;
#(
    parameter logic [31:0] HANDLER_VEC = 32'h0000_0800,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_IRQ-1:0]    irq,
    input  logic [SR_W-1:0]       sr_rd,
    input  logic [XLEN-1:0]       epc_rd,
    input  logic [XLEN-1:0]       pc_next,
    input  logic                  boundary,
    input  logic                  eret,
    output logic [CP0_ADDR_W-1:0] cp0_addr,
    output logic                  cp0_we,
    output logic [XLEN-1:0]       cp0_din,
    output logic                  stall,
    output logic                  redirect,
    output logic [XLEN-1:0]       redirect_pc,
    output logic [NUM_IRQ-1:0]    irq_pending
);

    state_t              state_q;
    state_t              state_n;
    logic [LINE_W-1:0]   line_q;
    logic [LINE_W-1:0]   line_n;
    logic [NUM_IRQ-1:0]  clr_c;
    logic [NUM_IRQ-1:0]  eligible_c;
    logic [LINE_W-1:0]   sel_line_c;
    logic                take_eret_c;
    logic                take_irq_c;

    cp0_wr_t             wr_q;
    cp0_wr_t             wr_n;
    logic                stall_q;
    logic                stall_n;
    logic                redir_q;
    logic                redir_n;
    logic [XLEN-1:0]     rpc_q;
    logic [XLEN-1:0]     rpc_n;

    irq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk         (clk),
        .rst         (rst),
        .irq         (irq),
        .clr         (clr_c),
        .irq_pending (irq_pending)
    );

    // Service-line clear is raised during REDIR for the captured line
    assign clr_c = (state_q == ST_REDIR) ? line_onehot(line_q) : '0;

    // Accept / ERET decision; ERET wins over a same-cycle interrupt
    assign eligible_c  = irq_pending & sr_rd[SR_IM_MSB:SR_IM_LSB];
    assign sel_line_c  = prio_line(eligible_c);
    assign take_eret_c = (state_q == ST_IDLE) && boundary && eret;
    assign take_irq_c  = (state_q == ST_IDLE) && boundary && sr_rd[SR_IE_BIT]
                         && (|eligible_c) && !eret;

    // Next state, captured line and next-cycle output decode
    always_comb begin
        state_n = state_q;
        line_n  = line_q;
        wr_n    = '0;
        stall_n = 1'b0;
        redir_n = 1'b0;
        rpc_n   = '0;

        case (state_q)
            ST_IDLE: begin
                if (take_eret_c) begin
                    state_n = ST_E_SR;
                end else if (take_irq_c) begin
                    state_n = ST_W_EPC;
                    line_n  = sel_line_c;
                end
            end
            ST_W_EPC:   state_n = ST_W_CAUSE;
            ST_W_CAUSE: state_n = ST_W_SR;
            ST_W_SR:    state_n = ST_REDIR;
            ST_REDIR:   state_n = ST_IDLE;
            ST_E_SR:    state_n = ST_E_REDIR;
            ST_E_REDIR: state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase

        // Outputs are decoded from the state being entered and registered,
        // so each one lines up with its state and no input reaches a port directly.
        // W_EPC is only entered from IDLE on accept, so pc_next here is the captured PC.
        case (state_n)
            ST_W_EPC: begin
                wr_n.addr = CP0_EPC;
                wr_n.we   = 1'b1;
                wr_n.din  = pc_next;
            end
            ST_W_CAUSE: begin
                wr_n.addr = CP0_CAUSE;
                wr_n.we   = 1'b1;
                wr_n.din  = cause_word(line_q);
            end
            ST_W_SR: begin
                wr_n.addr = CP0_SR;
                wr_n.we   = 1'b1;
                wr_n.din  = sr_word(sr_rd, 1'b0);
            end
            ST_E_SR: begin
                wr_n.addr = CP0_SR;
                wr_n.we   = 1'b1;
                wr_n.din  = sr_word(sr_rd, 1'b1);
            end
            ST_REDIR: begin
                redir_n = 1'b1;
                rpc_n   = HANDLER_VEC;
            end
            ST_E_REDIR: begin
                redir_n = 1'b1;
                rpc_n   = epc_rd;
            end
            default: begin
                wr_n = '0;
            end
        endcase

        stall_n = (state_n != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            wr_q    <= '0;
            stall_q <= 1'b0;
            redir_q <= 1'b0;
            rpc_q   <= '0;
        end else begin
            state_q <= state_n;
            line_q  <= line_n;
            wr_q    <= wr_n;
            stall_q <= stall_n;
            redir_q <= redir_n;
            rpc_q   <= rpc_n;
        end
    end

    assign cp0_addr    = wr_q.addr;
    assign cp0_we      = wr_q.we;
    assign cp0_din     = wr_q.din;
    assign stall       = stall_q;
    assign redirect    = redir_q;
    assign redirect_pc = rpc_q;

endmodule

// File: tb/tb_intr_seq.sv
// tb_intr_seq: scoreboard bench for intr_seq. Stimulus pushes the expected
// CP0 writes / redirects; a negedge monitor pops and compares on each output.
module tb_intr_seq;

    typedef struct {
        bit          is_redir;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [5:0]  irq;
    logic [15:0] sr_rd;
    logic [31:0] epc_rd;
    logic [31:0] pc_next;
    logic        boundary;
    logic        eret;
    logic [4:0]  cp0_addr;
    logic        cp0_we;
    logic [31:0] cp0_din;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [5:0]  irq_pending;

    int   vectors     = 0;
    int   miscompares = 0;
    bit   mon_en      = 0;
    exp_t exp_q[$];
    exp_t e_mon;

    intr_seq dut (
        .clk         (clk),
        .rst         (rst),
        .irq         (irq),
        .sr_rd       (sr_rd),
        .epc_rd      (epc_rd),
        .pc_next     (pc_next),
        .boundary    (boundary),
        .eret        (eret),
        .cp0_addr    (cp0_addr),
        .cp0_we      (cp0_we),
        .cp0_din     (cp0_din),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .irq_pending (irq_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_w(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.is_redir = 1'b0;
        e.addr     = a;
        e.data     = d;
        exp_q.push_back(e);
    endtask

    task automatic push_r(input logic [31:0] pc);
        exp_t e;
        e.is_redir = 1'b1;
        e.addr     = 5'd0;
        e.data     = pc;
        exp_q.push_back(e);
    endtask

    // Full interrupt entry for one line
    task automatic push_entry(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] sr);
        push_w(5'b01110, pc);
        push_w(5'b01101, cause);
        push_w(5'b01100, sr);
        push_r(32'h0000_0800);
    endtask

    task automatic pulse_irq(input logic [5:0] v);
        irq = v;
        tick(2);
        irq = 6'b0;
    endtask

    task automatic wait_pend(input logic [5:0] m);
        int n = 0;
        while (((irq_pending & m) != m) && n < 20) begin
            tick(1);
            n++;
        end
        check("pending_arrive", 32'((irq_pending & m) == m), 32'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick(1);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        tick(2);
    endtask

    // Monitor: every CP0 write or redirect must match the scoreboard head
    always @(negedge clk) begin
        if (mon_en && (cp0_we || redirect)) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious: we=%0b addr=%h din=%h redirect=%0b pc=%h, expected no output",
                         cp0_we, cp0_addr, cp0_din, redirect, redirect_pc);
            end else begin
                e_mon = exp_q.pop_front();
                check("stall_active", 32'(stall), 32'd1);
                if (e_mon.is_redir) begin
                    check("redirect", 32'(redirect), 32'd1);
                    check("redirect_pc", redirect_pc, e_mon.data);
                    check("redir_no_we", 32'(cp0_we), 32'd0);
                end else begin
                    check("cp0_we", 32'(cp0_we), 32'd1);
                    check("cp0_addr", 32'(cp0_addr), 32'(e_mon.addr));
                    check("cp0_din", cp0_din, e_mon.data);
                    check("write_no_redir", 32'(redirect), 32'd0);
                end
            end
        end
    end

    initial begin
        rst      = 1'b0;
        irq      = 6'b0;
        sr_rd    = 16'hFC01;
        epc_rd   = 32'h0000_0044;
        pc_next  = 32'h0000_0040;
        boundary = 1'b0;
        eret     = 1'b0;

        // Reset values
        tick(3);
        @(negedge clk);
        check("rst_cp0_we", 32'(cp0_we), 32'd0);
        check("rst_cp0_addr", 32'(cp0_addr), 32'd0);
        check("rst_cp0_din", cp0_din, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_redirect", 32'(redirect), 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_pending", 32'(irq_pending), 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;
        tick(2);

        // Single line 2 with boundary held high
        push_entry(32'h0000_0040, 32'h0000_1000, 32'h0000_FC00);
        boundary = 1'b1;
        pulse_irq(6'b000100);
        wait_drain();
        boundary = 1'b0;
        check("pend_after_l2", 32'(irq_pending), 32'd0);

        // Lines 1 and 4 together: 4 first, 1 stays pending
        pc_next = 32'h0000_0100;
        pulse_irq(6'b010010);
        wait_pend(6'b010010);
        push_entry(32'h0000_0100, 32'h0000_4000, 32'h0000_FC00);
        boundary = 1'b1;
        tick(1);
        boundary = 1'b0;
        wait_drain();
        check("pend_l1_left", 32'(irq_pending), 32'h02);

        // IE clear, then mask clear: no accept
        boundary = 1'b1;
        sr_rd    = 16'hFC00;
        tick(5);
        sr_rd    = 16'h0001;
        tick(5);
        check("masked_no_stall", 32'(stall), 32'd0);
        check("masked_pend", 32'(irq_pending), 32'h02);
        pc_next = 32'h0000_0120;
        push_entry(32'h0000_0120, 32'h0000_0800, 32'h0000_FC00);
        sr_rd = 16'hFC01;
        wait_drain();
        boundary = 1'b0;

        // ERET with IE clear in Status and line 3 pending
        pulse_irq(6'b001000);
        wait_pend(6'b001000);
        sr_rd = 16'hFC00;
        push_w(5'b01100, 32'h0000_FC01);
        push_r(32'h0000_0044);
        boundary = 1'b1;
        eret     = 1'b1;
        tick(1);
        boundary = 1'b0;
        eret     = 1'b0;
        wait_drain();

        // ERET beats an acceptable interrupt; interrupt taken at next boundary
        sr_rd = 16'hFC01;
        push_w(5'b01100, 32'h0000_FC01);
        push_r(32'h0000_0044);
        boundary = 1'b1;
        eret     = 1'b1;
        tick(1);
        boundary = 1'b0;
        eret     = 1'b0;
        wait_drain();
        check("eret_deferred_pend", 32'(irq_pending), 32'h08);
        pc_next = 32'h0000_0200;
        push_entry(32'h0000_0200, 32'h0000_2000, 32'h0000_FC00);
        boundary = 1'b1;
        tick(1);
        boundary = 1'b0;
        wait_drain();

        // Reset during W_CAUSE: EPC and Cause writes only
        pc_next = 32'h0000_0300;
        pulse_irq(6'b100000);
        wait_pend(6'b100000);
        push_w(5'b01110, 32'h0000_0300);
        push_w(5'b01101, 32'h0000_8000);
        boundary = 1'b1;
        tick(1);
        boundary = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);
        @(negedge clk);
        check("midrst_we", 32'(cp0_we), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_redirect", 32'(redirect), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        boundary = 1'b1;
        tick(10);
        boundary = 1'b0;
        check("midrst_queue", 32'(exp_q.size()), 32'd0);
        check("midrst_pend", 32'(irq_pending), 32'd0);

        // Line 0 edge during a line 4 sequence is kept and serviced next
        pc_next = 32'h0000_0400;
        pulse_irq(6'b010000);
        wait_pend(6'b010000);
        push_entry(32'h0000_0400, 32'h0000_4000, 32'h0000_FC00);
        push_entry(32'h0000_0400, 32'h0000_0400, 32'h0000_FC00);
        boundary = 1'b1;
        tick(1);
        check("seq_running", 32'(stall), 32'd1);
        pulse_irq(6'b000001);
        wait_drain();
        boundary = 1'b0;
        check("final_pend", 32'(irq_pending), 32'd0);

        tick(3);
        mon_en = 1'b0;
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
